// File: rtl/sram_test_sequencer_if.sv
// Request port between the SRAM self-test sequencer and the SRAM controller.
// The sequencer is the sole master; the controller is the slave.
interface sram_test_sequencer_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
) ();
  logic              start;
  logic              rw;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              data_ready;
  logic              busy;

  modport master (
    output start, rw, addr, wdata,
    input  rdata, data_ready, busy
  );

  modport slave (
    input  start, rw, addr, wdata,
    output rdata, data_ready, busy
  );
endinterface

// File: rtl/sram_test_sequencer.sv
// SRAM self-test sequencer: writes a pattern to addresses 0..LAST_ADDR, reads
// them back and compares, reporting pass/fail, a saturating error count, the
// first failing address/data and a per-access handshake timeout.
//
// state    | meaning
// IDLE     | waiting for start; results of the last run held
// WR_ISSUE | ctrl.start high for one cycle, write request on the bus
// WR_WAIT  | waiting for controller busy to rise then fall
// RD_ISSUE | ctrl.start high for one cycle, read request on the bus
// RD_WAIT  | waiting for busy rise/fall and data_ready; compare read data
// FINISH   | done pulse; pass/timeout valid
module sram_test_sequencer #(
  parameter int                ADDR_W    = 19,
  parameter int                DATA_W    = 8,
  parameter logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'('h7FFFF),
  parameter int                TIMEOUT   = 15,
  parameter int                ERR_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           pattern_sel,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic [ERR_W-1:0]     err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic [DATA_W-1:0]    first_err_data,
  sram_test_sequencer_if.master ctrl
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ISSUE,
    WR_WAIT,
    RD_ISSUE,
    RD_WAIT,
    FINISH
  } state_t;

  state_t            state;
  logic [1:0]        pat_sel;
  logic [CNT_W-1:0]  cnt;
  logic              seen_busy;
  logic              seen_ready;

  logic [DATA_W-1:0] exp_data;
  logic [ADDR_W-1:0] addr_inc;
  logic              last_addr;
  logic              busy_fell;
  logic              mismatch;
  logic              cnt_expired;
  logic [ERR_W-1:0]  err_next;

  function automatic logic [DATA_W-1:0] pattern_of(input logic [1:0] sel,
                                                   input logic [7:0] a);
    logic [DATA_W-1:0] p;
    case (sel)
      2'd0:    p = DATA_W'(8'h55);
      2'd1:    p = DATA_W'(8'hAA);
      2'd2:    p = DATA_W'(a);
      default: p = DATA_W'(~a);
    endcase
    return p;
  endfunction

  assign exp_data    = pattern_of(pat_sel, ctrl.addr[7:0]);
  assign addr_inc    = ctrl.addr + ADDR_W'(1);
  assign last_addr   = (ctrl.addr == LAST_ADDR);
  // An access is complete only once busy has been seen high and is now low.
  assign busy_fell   = seen_busy && !ctrl.busy;
  // Only the first data_ready of a read is compared.
  assign mismatch    = (state == RD_WAIT) && ctrl.data_ready && !seen_ready &&
                       (ctrl.rdata != exp_data);
  assign cnt_expired = (cnt == CNT_W'(TIMEOUT - 1));
  assign err_next    = (mismatch && (err_count != '1)) ? err_count + ERR_W'(1)
                                                       : err_count;

  // Test sequencing FSM; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      pat_sel        <= 2'd0;
      cnt            <= '0;
      seen_busy      <= 1'b0;
      seen_ready     <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      ctrl.start     <= 1'b0;
      ctrl.rw        <= 1'b1;
      ctrl.addr      <= '0;
      ctrl.wdata     <= '0;
    end else begin
      ctrl.start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat_sel        <= pattern_sel;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_data <= '0;
            timeout        <= 1'b0;
            pass           <= 1'b0;
            busy           <= 1'b1;
            ctrl.rw        <= 1'b0;
            ctrl.addr      <= '0;
            ctrl.wdata     <= pattern_of(pattern_sel, 8'h00);
            ctrl.start     <= 1'b1;
            cnt            <= '0;
            state          <= WR_ISSUE;
          end
        end
        WR_ISSUE: begin
          seen_busy <= 1'b0;
          cnt       <= cnt + CNT_W'(1);
          state     <= WR_WAIT;
        end
        WR_WAIT: begin
          if (ctrl.busy) seen_busy <= 1'b1;
          cnt <= cnt + CNT_W'(1);
          if (busy_fell) begin
            cnt        <= '0;
            ctrl.start <= 1'b1;
            if (last_addr) begin
              ctrl.addr <= '0;
              ctrl.rw   <= 1'b1;
              state     <= RD_ISSUE;
            end else begin
              ctrl.addr  <= addr_inc;
              ctrl.wdata <= pattern_of(pat_sel, addr_inc[7:0]);
              state      <= WR_ISSUE;
            end
          end else if (cnt_expired) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= FINISH;
          end
        end
        RD_ISSUE: begin
          seen_busy  <= 1'b0;
          seen_ready <= 1'b0;
          cnt        <= cnt + CNT_W'(1);
          state      <= RD_WAIT;
        end
        RD_WAIT: begin
          if (ctrl.busy) seen_busy <= 1'b1;
          if (ctrl.data_ready) seen_ready <= 1'b1;
          cnt       <= cnt + CNT_W'(1);
          err_count <= err_next;
          // A zero count means no earlier mismatch; saturation never returns it to zero.
          if (mismatch && (err_count == '0)) begin
            first_err_addr <= ctrl.addr;
            first_err_data <= ctrl.rdata;
          end
          if (busy_fell && (seen_ready || ctrl.data_ready)) begin
            if (last_addr) begin
              pass  <= (err_next == '0);
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              cnt        <= '0;
              ctrl.addr  <= addr_inc;
              ctrl.start <= 1'b1;
              state      <= RD_ISSUE;
            end
          end else if (cnt_expired) begin
            timeout <= 1'b1;
            pass    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= FINISH;
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
